// File: rtl/alu_arb_pkg.sv
// Shared types for the round-robin ALU arbiter: opcode and sequencer state encodings.
package alu_arb_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_exec.sv
// Combinational ALU operation library: one N-bit result per opcode.
module alu_op_exec
  import alu_arb_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  op_e          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out
);

  localparam int unsigned SH_W = $clog2(N);

  logic [SH_W-1:0] amt;
  logic [2*N-1:0]  rol_w;
  logic [2*N-1:0]  ror_w;

  // Rotates shift a doubled copy of a; only the low log2(N) bits of b count.
  always_comb begin
    amt   = b[SH_W-1:0];
    rol_w = {a, a} << amt;
    ror_w = {a, a} >> amt;
    out   = a;
    case (op)
      OP_ADD:  out = a + b;
      OP_SUB:  out = a - b;
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_ROL:  out = rol_w[2*N-1:N];
      OP_ROR:  out = ror_w[N-1:0];
      OP_PASS: out = a;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter sharing one ALU stage among NUM_REQ requesters;
// one op in flight, result returned tagged with the owning requester ID.
module alu_op_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int unsigned N       = 8,
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [3*NUM_REQ-1:0]   req_op,
  input  logic [N*NUM_REQ-1:0]   req_a,
  input  logic [N*NUM_REQ-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [N-1:0]           rsp_data,
  output logic [2:0]             rsp_op
);

  state_e          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] id_q;
  op_e             op_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    exec_out;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  int unsigned     cand;
  logic [ID_W-1:0] cand_id;

  op_e             sel_op;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;

  // Search starts just after the previous winner, so it has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_id     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand    = (32'(last_grant) + i) % NUM_REQ;
      cand_id = ID_W'(cand);
      if (!grant_found && req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
  end

  // Only the winner's fields are muxed, so idle requesters' operands never leak in.
  always_comb begin
    sel_op = op_e'(req_op[3*32'(grant_idx) +: 3]);
    sel_a  = req_a[N*32'(grant_idx) +: N];
    sel_b  = req_b[N*32'(grant_idx) +: N];
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == ST_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  alu_op_exec #(
    .N (N)
  ) u_exec (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .out (exec_out)
  );

  // Sequencer: IDLE accepts, EXEC registers the result, RESP holds it until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_op     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            id_q       <= grant_idx;
            last_grant <= grant_idx;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= exec_out;
          rsp_id    <= id_q;
          rsp_op    <= op_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Scoreboard bench for alu_op_arbiter: queue-based round-robin model plus
// an arithmetic ALU reference; a separate monitor checks every response.
module tb_alu_op_arbiter;

  localparam int N       = 8;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_op;
  logic [N*NUM_REQ-1:0] req_a;
  logic [N*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [N-1:0]         rsp_data;
  logic [2:0]           rsp_op;

  alu_op_arbiter #(
    .N       (N),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op)
  );

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } req_t;

  typedef struct {
    int           id;
    logic [2:0]   op;
    logic [N-1:0] data;
    int           cyc;
  } exp_t;

  req_t rq[NUM_REQ][$];
  exp_t exp_q[$];

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int last     = NUM_REQ - 1;
  int prev_acc = -1;
  bit busy       = 1'b0;
  bit rr_chk     = 1'b0;
  bit prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference ALU: plain modular arithmetic and bit-by-bit rotation.
  function automatic logic [N-1:0] model(input logic [2:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [N-1:0] x;
    int s;
    x = a;
    s = int'(b) % N;
    case (op)
      3'd0: x = N'((int'(a) + int'(b)) % (1 << N));
      3'd1: x = N'((int'(a) - int'(b) + (1 << N)) % (1 << N));
      3'd2: x = a & b;
      3'd3: x = a | b;
      3'd4: x = a ^ b;
      3'd5: repeat (s) x = {x[N-2:0], x[N-1]};
      3'd6: repeat (s) x = {x[0], x[N-1:1]};
      default: x = a;
    endcase
    return x;
  endfunction

  function automatic int pending();
    int t = 0;
    for (int r = 0; r < NUM_REQ; r++) t += rq[r].size();
    return t;
  endfunction

  task automatic push_req(input int r, input logic [2:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b);
    req_t q;
    q.op = op;
    q.a  = a;
    q.b  = b;
    rq[r].push_back(q);
  endtask

  // Idle requesters carry random garbage on their operand lanes.
  task automatic drive();
    for (int r = 0; r < NUM_REQ; r++) begin
      if (rq[r].size() > 0) begin
        req_valid[r]     = 1'b1;
        req_op[3*r +: 3] = rq[r][0].op;
        req_a[N*r +: N]  = rq[r][0].a;
        req_b[N*r +: N]  = rq[r][0].b;
      end else begin
        req_valid[r]     = 1'b0;
        req_op[3*r +: 3] = 3'($urandom);
        req_a[N*r +: N]  = N'($urandom);
        req_b[N*r +: N]  = N'($urandom);
      end
    end
  endtask

  // Predict the grant from the pending queues and the previous winner.
  task automatic observe();
    logic [NUM_REQ-1:0] expr;
    int   w;
    exp_t e;
    expr = '0;
    w    = -1;
    if (!rst && !busy) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        int c;
        c = (last + i) % NUM_REQ;
        if (w < 0 && rq[c].size() > 0) w = c;
      end
    end
    if (w >= 0) expr[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(expr));
    if (w >= 0) begin
      e.id   = w;
      e.op   = rq[w][0].op;
      e.data = model(rq[w][0].op, rq[w][0].a, rq[w][0].b);
      e.cyc  = cyc;
      exp_q.push_back(e);
      if (rr_chk && prev_acc >= 0) chk("op_spacing", 32'(cyc - prev_acc), 32'd3);
      prev_acc = cyc;
      void'(rq[w].pop_front());
      last = w;
      busy = 1'b1;
    end else if (!rst && rsp_valid && rsp_ready) begin
      busy = 1'b0;
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() > 0 || pending() > 0) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL timeout_%s: got still busy after %0d cycles expected idle", tag, n);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    busy     = 1'b0;
    last     = NUM_REQ - 1;
    prev_acc = -1;
  endtask

  // Response monitor: latency on rise, payload every valid cycle (covers stability).
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id=%0d data=0x%0h expected no response",
                   rsp_id, rsp_data);
        end else begin
          if (!prev_valid) chk("latency", 32'(cyc), 32'(exp_q[0].cyc + 2));
          chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
          chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
          chk("rsp_op", 32'(rsp_op), 32'(exp_q[0].op));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = rsp_valid && !rsp_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rsp_ready = 1'b0;
    drive();
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_op", 32'(rsp_op), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Single ADD with carry out dropped.
    push_req(0, 3'd0, 8'hF0, 8'h20);
    wait_idle("add");

    // Rotates, SUB underflow, PASS and logic ops across both requesters.
    push_req(0, 3'd5, 8'h81, 8'h01);
    push_req(1, 3'd6, 8'h81, 8'h09);
    push_req(0, 3'd5, 8'h5A, 8'h08);
    push_req(1, 3'd1, 8'h00, 8'h01);
    push_req(0, 3'd7, 8'h3C, 8'h99);
    push_req(1, 3'd2, 8'hCC, 8'hAA);
    push_req(0, 3'd3, 8'hCC, 8'hAA);
    push_req(1, 3'd4, 8'hCC, 8'hAA);
    wait_idle("directed");

    // Round robin with both requesters continuously valid.
    rr_chk   = 1'b1;
    prev_acc = -1;
    for (int k = 0; k < 2; k++) begin
      push_req(0, 3'd0, 8'(k), 8'h11);
      push_req(1, 3'd4, 8'(k + 8'h40), 8'h0F);
    end
    wait_idle("rr");
    rr_chk = 1'b0;

    // Backpressure: response held for 5 cycles, a second request waits.
    rsp_ready = 1'b0;
    push_req(0, 3'd4, 8'hCC, 8'hAA);
    push_req(1, 3'd7, 8'h3C, 8'h00);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (5) step();
    rsp_ready = 1'b1;
    wait_idle("bp");

    // Reset while the op is in EXEC; both requesters pending afterwards.
    push_req(1, 3'd0, 8'h01, 8'h02);
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    push_req(0, 3'd1, 8'h10, 8'h01);
    push_req(1, 3'd3, 8'h01, 8'h80);
    drive();
    rst = 1'b1;
    #1;
    chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exec_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    wait_idle("rst_exec");

    // Reset while a response is being held.
    rsp_ready = 1'b0;
    push_req(1, 3'd3, 8'h0C, 8'h30);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_data", 32'(rsp_data), 32'd0);
    chk("rst_resp_id", 32'(rsp_id), 32'd0);
    chk("rst_resp_op", 32'(rsp_op), 32'd0);
    model_reset();
    rsp_ready = 1'b1;
    step();
    rst = 1'b0;
    push_req(1, 3'd0, 8'h05, 8'h05);
    push_req(0, 3'd0, 8'h07, 8'h07);
    wait_idle("rst_resp");

    // Random traffic with random consumer backpressure.
    for (int c = 0; c < 700; c++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (rq[r].size() == 0 && ($urandom % 3) == 0)
          push_req(r, 3'($urandom), N'($urandom), N'($urandom));
      end
      rsp_ready = ($urandom % 4) != 0;
      step();
    end
    rsp_ready = 1'b1;
    wait_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_arbiter.md
Name: alu_op_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one N-bit ALU execution stage among NUM_REQ requesters.
- Each requester presents opcode plus operands a and b over a valid/ready handshake.
- The block grants one requester, captures its operands, executes the op, and returns the result tagged with the requester ID over a valid/ready response channel.
- One operation is in flight at a time. The block sits between the requester front-ends and the ALU operation library.

Parameters:
- N, 8, data width; power of 2, >= 2
- NUM_REQ, 2, number of requesters; >= 2
- ID_W, $clog2(NUM_REQ), width of the requester ID (derived; not overridden)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_op  in  3*NUM_REQ  opcode; requester r at [3r+2:3r]
- req_a  in  N*NUM_REQ  operand a; requester r at [N*r+N-1:N*r]
- req_b  in  N*NUM_REQ  operand b, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of requester that owns the result
- rsp_data  out  N  result
- rsp_op  out  3  opcode of the result

Behaviour:
- Reset (async, immediate):
  - state=IDLE
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_op=0
  - last_grant=NUM_REQ-1, so requester 0 wins first
  - req_ready=0 while rst is high
  - An in-flight op is discarded.
- States:
  - IDLE -> EXEC on request handshake
  - EXEC -> RESP unconditionally
  - RESP -> IDLE when rsp_valid && rsp_ready
- IDLE arbitration:
  - winner g is the first r with req_valid[r]=1, searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in IDLE only; all other bits are 0.
  - The handshake is req_valid[g] && req_ready[g]. On it: capture op_q, a_q, b_q, id_q=g; last_grant<=g.
  - req_ready=0 in EXEC and RESP.
  - No valid request: stay in IDLE; last_grant unchanged.
- EXEC: compute the result from the captured registers; register it into rsp_data, with rsp_id<=id_q and rsp_op<=op_q.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_op are held stable until the handshake.
  - On the handshake, rsp_valid<=0 and state<=IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- Latency: request accepted in cycle 0 (edge 0); rsp_valid high in cycle 2. Minimum spacing is 3 cycles per op when rsp_ready=1.
- Opcodes (3 bits, all defined):
  - 0 ADD: a+b mod 2^N, carry dropped
  - 1 SUB: a-b mod 2^N
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 ROL: a rotated left by b[$clog2(N)-1:0]; upper bits of b ignored
  - 6 ROR: same amount rule as ROL
  - 7 PASS: out=a
- Rotate boundaries: amount 0 gives a; for N=8, b=8 gives a (b[2:0]=0).
- Fairness: the requester that was just granted has the lowest priority next time.
- Requests that drop req_valid before being granted are simply not served. No X-propagation from unselected requesters' operands.

Decomposition:
- Package alu_arb_pkg:
  - opcode enum OP_ADD..OP_PASS (3 bits)
  - state enum ST_IDLE, ST_EXEC, ST_RESP
- Sub-module alu_op_exec: combinational, parameter N; ports op, a, b, out. Implements the opcode table. The arbiter holds all sequential state.

Test Plan:
- Reset: assert rst mid-EXEC with N=8 -> rsp_valid=0 and req_ready=0 immediately; after release, requester 0 is granted first.
- Single request: r0 ADD a=0xF0, b=0x20, rsp_ready=1 -> rsp_valid in cycle 2, rsp_data=0x10, rsp_id=0, rsp_op=0.
- Rotates:
  - ROL a=0x81, b=0x01 -> 0x03
  - ROR a=0x81, b=0x09 -> 0xC0 (amount 1)
  - ROL a=0x5A, b=0x08 -> 0x5A
- Round-robin: both requesters hold valid for 4 ops -> grant order 0,1,0,1; rsp_id matches; each op 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0; raise rsp_ready -> IDLE next cycle.
- SUB underflow and PASS: SUB a=0x00, b=0x01 -> 0xFF; PASS a=0x3C -> 0x3C; AND/OR/XOR of 0xCC,0xAA -> 0x88/0xEE/0x66.
